pc_sequencer: RTL and testbench

//  Multicycle control FSM that sequences the PC register and next-PC helper.

---
 rtl/pc_sequencer_pkg.sv | 52 +++++
 rtl/pc_sequencer_hs.sv | 28 ++
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the multicycle PC sequencer: next-PC selects,
// FSM state codes, opcode values and the bundled control-output struct.
// Latency: n/a (constants only). Backpressure: n/a.
package pc_sequencer_pkg;

    // Next-PC mux selects; PC_HOLD is presented whenever pc_we is low.
    localparam logic [1:0] PC_NEXT_INS = 2'b00;
    localparam logic [1:0] PC_REL_JMP  = 2'b01;
    localparam logic [1:0] PC_ABS_JMP  = 2'b10;
    localparam logic [1:0] PC_HOLD     = 2'b11;

    // FSM state encodings.
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    // Combinational control outputs, grouped so the decode can default them in one go.
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_we;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{imem_req: 1'b0, dmem_req: 1'b0, ir_we: 1'b0,
                                    pc_we: 1'b0, pc_sel: PC_HOLD, reg_we: 1'b0};

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ORI, OP_LW, OP_SW, OP_HLT: op_legal = 1'b1;
            default:                      op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_hs.sv
// Handshake wait timer: counts cycles a request waits without ack, flags expiry.
// Latency: expire is combinational from the count and the current req/ack.
// Backpressure: none; ack in the expiry cycle suppresses expire (ack wins).
// Ports: clk, rst (sync, active-high), clear (state change), req, ack -> expire.
module hs_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic expire
);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= 8'd0;
        end else if (req && !ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign expire = req && !ack && (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB control FSM driving PC, IR and register-file enables.
// Latency (zero-wait memory): J 2, BEQ/BNE 3, R/ADDI/ORI/SW 4, LW 5 cycles.
// Backpressure: stalls in IF/MEM until imem_ack/dmem_ack; TIMEOUT unacked cycles -> err + HALT.
// Ports: clk, RST (sync, active-high); opcode, zero, imem_ack, dmem_ack in;
//        imem_req, dmem_req, ir_we, pc_we, pc_sel, reg_we (comb) and halted, err, retired (reg) out.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic        halted,
    output logic        err,
    output logic [31:0] retired
);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    ctrl_t       ctrl;
    logic        err_set;
    logic        retire;
    logic        halted_q;
    logic        err_q;
    logic [31:0] retired_q;

    // Timer request/ack derived from state rather than the decoded outputs,
    // which keeps expire -> decode free of a combinational loop.
    logic hs_req;
    logic hs_ack;
    logic expire;

    assign hs_req = (state == S_IF) || (state == S_MEM);
    assign hs_ack = (state == S_IF) ? imem_ack : dmem_ack;

    hs_timer #(.TIMEOUT(TIMEOUT)) u_hs_timer (
        .clk    (clk),
        .rst    (RST),
        .clear  (state_nxt != state),
        .req    (hs_req),
        .ack    (hs_ack),
        .expire (expire)
    );

    always_comb begin
        ctrl      = CTRL_IDLE;
        state_nxt = state;
        err_set   = 1'b0;
        retire    = 1'b0;

        case (state)
            S_IF: begin
                ctrl.imem_req = 1'b1;
                if (imem_ack) begin
                    ctrl.ir_we = 1'b1;
                    state_nxt  = S_ID;
                end else if (expire) begin
                    err_set   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_ID: begin
                if (opcode == OP_J) begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = PC_ABS_JMP;
                    retire      = 1'b1;
                    state_nxt   = S_IF;
                end else if (opcode == OP_HLT) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else if (!op_legal(opcode)) begin
                    err_set   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_BEQ, OP_BNE: begin
                        ctrl.pc_we = 1'b1;
                        // BEQ takes on zero, BNE on !zero; opcode[0] distinguishes them.
                        ctrl.pc_sel = (zero ^ opcode[0]) ? PC_REL_JMP : PC_NEXT_INS;
                        retire      = 1'b1;
                        state_nxt   = S_IF;
                    end
                    OP_LW, OP_SW:         state_nxt = S_MEM;
                    OP_R, OP_ADDI, OP_ORI: state_nxt = S_WB;
                    // IR is stable after ID, so anything else here means a corrupted
                    // instruction word; treat it like an illegal opcode.
                    default: begin
                        err_set   = 1'b1;
                        state_nxt = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                ctrl.dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (opcode == OP_SW) begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PC_NEXT_INS;
                        retire      = 1'b1;
                        state_nxt   = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (expire) begin
                    err_set   = 1'b1;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                ctrl.reg_we = 1'b1;
                ctrl.pc_we  = 1'b1;
                ctrl.pc_sel = PC_NEXT_INS;
                retire      = 1'b1;
                state_nxt   = S_IF;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IF;
            end
        endcase

        // Reset abandons the instruction in flight: no enables escape this cycle.
        if (RST) begin
            ctrl      = CTRL_IDLE;
            state_nxt = S_IF;
            err_set   = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IF;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state    <= state_nxt;
            halted_q <= (state_nxt == S_HALT);
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign imem_req = ctrl.imem_req;
    assign dmem_req = ctrl.dmem_req;
    assign ir_we    = ctrl.ir_we;
    assign pc_we    = ctrl.pc_we;
    assign pc_sel   = ctrl.pc_sel;
    assign reg_we   = ctrl.reg_we;
    assign halted   = halted_q;
    assign err      = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (TIMEOUT=4): the driver pushes the
// hand-computed per-cycle response into a scoreboard queue and a monitor on
// the falling edge pops and compares it against the DUT outputs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, ir_we, pc_we, reg_we, halted, err;
    logic [1:0]  pc_sel;
    logic [31:0] retired;

    always #5 clk = ~clk;

    pc_sequencer #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .RST      (RST),
        .opcode   (opcode),
        .zero     (zero),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .reg_we   (reg_we),
        .halted   (halted),
        .err      (err),
        .retired  (retired)
    );

    // Control vector {imem_req, dmem_req, ir_we, pc_we, pc_sel[1:0], reg_we}.
    localparam logic [6:0] C_IDLE  = 7'b0000110;
    localparam logic [6:0] C_IF    = 7'b1000110;
    localparam logic [6:0] C_IFACK = 7'b1010110;
    localparam logic [6:0] C_MEM   = 7'b0100110;
    localparam logic [6:0] C_MEMSW = 7'b0101000;
    localparam logic [6:0] C_WB    = 7'b0001001;
    localparam logic [6:0] C_NEXT  = 7'b0001000;
    localparam logic [6:0] C_REL   = 7'b0001010;
    localparam logic [6:0] C_ABS   = 7'b0001100;

    localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, LW = 6'b100011,
                           SW = 6'b101011, HLT = 6'b111111, BAD = 6'b111110;

    typedef struct {
        logic [6:0]  ctl;
        logic        halted;
        logic        err;
        logic [31:0] retired;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string nm, input string what, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, want);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare whenever one is expected.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(x.name, "ctl", 32'({imem_req, dmem_req, ir_we, pc_we, pc_sel, reg_we}), 32'(x.ctl));
                check(x.name, "halted", 32'(halted), 32'(x.halted));
                check(x.name, "err", 32'(err), 32'(x.err));
                check(x.name, "retired", retired, x.retired);
            end
        end
    end

    // One cycle of stimulus plus (optionally) its expected response.
    task automatic cyc(input logic rst_i, input logic [5:0] op, input logic z,
                       input logic ia, input logic da, input logic chk,
                       input logic [6:0] ctl, input logic h, input logic e,
                       input logic [31:0] r, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        RST = rst_i; opcode = op; zero = z; imem_ack = ia; dmem_ack = da;
        if (chk) begin
            x.ctl = ctl; x.halted = h; x.err = e; x.retired = r; x.name = nm;
            sb.push_back(x);
        end
    endtask

    initial begin
        // 1. Reset for two cycles; first cycle state is unknown, second is checked.
        cyc(1, R, 0, 0, 0, 0, C_IDLE, 0, 0, 0, "rst0");
        cyc(1, R, 0, 0, 0, 1, C_IDLE, 0, 0, 0, "rst1");
        cyc(0, R, 0, 0, 0, 1, C_IF,   0, 0, 0, "post_rst_if");

        // 2. Zero-wait R-type.
        cyc(0, R, 0, 1, 0, 1, C_IFACK, 0, 0, 0, "r_if");
        cyc(0, R, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "r_id");
        cyc(0, R, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "r_ex");
        cyc(0, R, 0, 0, 0, 1, C_WB,    0, 0, 0, "r_wb");

        // 3. Branches and jump.
        cyc(0, BEQ, 1, 1, 0, 1, C_IFACK, 0, 0, 1, "beq_if");
        cyc(0, BEQ, 1, 0, 0, 1, C_IDLE,  0, 0, 1, "beq_id");
        cyc(0, BEQ, 1, 0, 0, 1, C_REL,   0, 0, 1, "beq_taken");
        cyc(0, BNE, 1, 1, 0, 1, C_IFACK, 0, 0, 2, "bne_if");
        cyc(0, BNE, 1, 0, 0, 1, C_IDLE,  0, 0, 2, "bne_id");
        cyc(0, BNE, 1, 0, 0, 1, C_NEXT,  0, 0, 2, "bne_not_taken");
        cyc(0, J,   0, 1, 0, 1, C_IFACK, 0, 0, 3, "j_if");
        cyc(0, J,   0, 0, 0, 1, C_ABS,   0, 0, 3, "j_id");
        cyc(0, BEQ, 0, 1, 0, 1, C_IFACK, 0, 0, 4, "beq0_if");
        cyc(0, BEQ, 0, 0, 0, 1, C_IDLE,  0, 0, 4, "beq0_id");
        cyc(0, BEQ, 0, 0, 0, 1, C_NEXT,  0, 0, 4, "beq0_not_taken");

        // 4. LW with dmem_ack three cycles late: ack lands on the expiry cycle and wins.
        cyc(0, LW, 0, 1, 0, 1, C_IFACK, 0, 0, 5, "lw_if");
        cyc(0, LW, 0, 0, 0, 1, C_IDLE,  0, 0, 5, "lw_id");
        cyc(0, LW, 0, 0, 0, 1, C_IDLE,  0, 0, 5, "lw_ex");
        cyc(0, LW, 0, 0, 0, 1, C_MEM,   0, 0, 5, "lw_mem0");
        cyc(0, LW, 0, 0, 0, 1, C_MEM,   0, 0, 5, "lw_mem1");
        cyc(0, LW, 0, 0, 0, 1, C_MEM,   0, 0, 5, "lw_mem2");
        cyc(0, LW, 0, 0, 1, 1, C_MEM,   0, 0, 5, "lw_mem3_ack");
        cyc(0, LW, 0, 0, 0, 1, C_WB,    0, 0, 5, "lw_wb");

        // Zero-wait SW.
        cyc(0, SW, 0, 1, 0, 1, C_IFACK, 0, 0, 6, "sw_if");
        cyc(0, SW, 0, 0, 0, 1, C_IDLE,  0, 0, 6, "sw_id");
        cyc(0, SW, 0, 0, 0, 1, C_IDLE,  0, 0, 6, "sw_ex");
        cyc(0, SW, 0, 0, 1, 1, C_MEMSW, 0, 0, 6, "sw_mem");

        // 5b. imem_ack on the 4th request cycle: fetch completes, no error. Then HLT.
        cyc(0, HLT, 0, 0, 0, 1, C_IF,    0, 0, 7, "late_if0");
        cyc(0, HLT, 0, 0, 0, 1, C_IF,    0, 0, 7, "late_if1");
        cyc(0, HLT, 0, 0, 0, 1, C_IF,    0, 0, 7, "late_if2");
        cyc(0, HLT, 0, 1, 0, 1, C_IFACK, 0, 0, 7, "late_if3_ack");
        cyc(0, HLT, 0, 0, 0, 1, C_IDLE,  0, 0, 7, "hlt_id");
        cyc(0, HLT, 0, 0, 0, 1, C_IDLE,  1, 0, 8, "halt0");
        cyc(0, R,   0, 1, 1, 1, C_IDLE,  1, 0, 8, "halt_absorb");

        // 5a. Timeout with imem_ack withheld for four request cycles.
        cyc(1, R, 0, 0, 0, 1, C_IDLE, 1, 0, 8, "rst_from_halt");
        cyc(0, R, 0, 0, 0, 1, C_IF,   0, 0, 0, "to_if0");
        cyc(0, R, 0, 0, 0, 1, C_IF,   0, 0, 0, "to_if1");
        cyc(0, R, 0, 0, 0, 1, C_IF,   0, 0, 0, "to_if2");
        cyc(0, R, 0, 0, 0, 1, C_IF,   0, 0, 0, "to_if3");
        cyc(0, R, 0, 0, 0, 1, C_IDLE, 1, 1, 0, "to_halt");
        cyc(0, R, 0, 1, 0, 1, C_IDLE, 1, 1, 0, "to_halt_ack_ignored");

        // 6. Illegal opcode: error, HALT, no retire.
        cyc(1, R,   0, 0, 0, 1, C_IDLE,  1, 1, 0, "rst_from_to");
        cyc(0, BAD, 0, 1, 0, 1, C_IFACK, 0, 0, 0, "bad_if");
        cyc(0, BAD, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "bad_id");
        cyc(0, BAD, 0, 0, 0, 1, C_IDLE,  1, 1, 0, "bad_halt");

        // Retired counter wrap: preload FFFFFFFF during J's ID cycle.
        cyc(1, J, 0, 0, 0, 1, C_IDLE,  1, 1, 0, "rst_from_bad");
        cyc(0, J, 0, 1, 0, 1, C_IFACK, 0, 0, 0, "wrap_if");
        cyc(0, J, 0, 0, 0, 1, C_ABS,   0, 0, 32'hFFFF_FFFF, "wrap_id");
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;

        // Reset during MEM: ack in the reset cycle must not produce pc_we or a retire.
        cyc(0, SW, 0, 1, 0, 1, C_IFACK, 0, 0, 0, "rstmem_if");
        cyc(0, SW, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "rstmem_id");
        cyc(0, SW, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "rstmem_ex");
        cyc(0, SW, 0, 0, 0, 1, C_MEM,   0, 0, 0, "rstmem_mem");
        cyc(1, SW, 0, 0, 1, 1, C_IDLE,  0, 0, 0, "rstmem_rst");
        cyc(0, ADDI, 0, 0, 0, 1, C_IF,  0, 0, 0, "rstmem_back_if");

        // Zero-wait ADDI after recovery.
        cyc(0, ADDI, 0, 1, 0, 1, C_IFACK, 0, 0, 0, "addi_if");
        cyc(0, ADDI, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "addi_id");
        cyc(0, ADDI, 0, 0, 0, 1, C_IDLE,  0, 0, 0, "addi_ex");
        cyc(0, ADDI, 0, 0, 0, 1, C_WB,    0, 0, 0, "addi_wb");
        cyc(0, R,    0, 0, 0, 1, C_IF,    0, 0, 1, "addi_done");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
